// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with clear, load, wrap and illegal-load flags.
// One-cycle latency for count/wrap/load_err, tc is combinational; no backpressure, steps every enabled edge.
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                up,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                wrap,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic [W-1:0] load_clean;
  logic         all_nine;
  logic         all_zero;
  logic         load_bad;

  // Carry/borrow survive past the top digit only when every digit is 9 / 0,
  // so the chain outputs double as the terminal-count detectors.
  always_comb begin
    logic [3:0] d;
    logic       cy;
    logic       bw;
    d          = 4'd0;
    cy         = 1'b1;
    bw         = 1'b1;
    inc_val    = count;
    dec_val    = count;
    load_clean = '0;
    load_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (cy) begin
        inc_val[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
        cy = (d == 4'd9);
      end
      if (bw) begin
        dec_val[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
        bw = (d == 4'd0);
      end
      d = load_val[4*i +: 4];
      if (d > 4'd9) begin
        load_bad = 1'b1;
      end else begin
        load_clean[4*i +: 4] = d;
      end
    end
    all_nine = cy;
    all_zero = bw;
  end

  assign tc = en & (up ? all_nine : all_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count    <= load_clean;
        load_err <= load_bad;
      end else if (en) begin
        count <= up ? inc_val : dec_val;
        wrap  <= up ? all_nine : all_zero;
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter with DIGITS=2.
module tb_bcd_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, clr, load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       tc, wrap, load_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] cnt;
    logic       wrap;
    logic       err;
  } exp_t;

  typedef struct {
    logic       en, up, clr, load;
    logic [7:0] lv;
    logic [7:0] cnt;
    logic       wrap, err;
  } vec_t;

  exp_t       sb[$];
  vec_t       vt[$];
  logic [7:0] exp_cnt;

  bcd_updown_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrap     (wrap),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // Drive one cycle of inputs, check tc before the edge, push the expected
  // registered outputs and pop/compare them once the edge has happened.
  task automatic step(input logic e, input logic u, input logic c, input logic l,
                      input logic [7:0] lv, input logic [7:0] ecnt,
                      input logic ew, input logic ee);
    exp_t x;
    logic etc;
    en = e; up = u; clr = c; load = l; load_val = lv;
    #1;
    etc = e & ((u && exp_cnt == 8'h99) || (!u && exp_cnt == 8'h00));
    chk("tc", {31'd0, tc}, {31'd0, etc});
    x.cnt = ecnt; x.wrap = ew; x.err = ee;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      chk("count", {24'd0, count}, {24'd0, x.cnt});
      chk("wrap", {31'd0, wrap}, {31'd0, x.wrap});
      chk("load_err", {31'd0, load_err}, {31'd0, x.err});
      exp_cnt = x.cnt;
    end
  endtask

  task automatic idle(input logic [7:0] ecnt);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, ecnt, 1'b0, 1'b0);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear without a clock edge.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_count", {24'd0, count}, 32'd0);
    chk("rst_wrap", {31'd0, wrap}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    rst_n = 1'b1;
    exp_cnt = 8'h00;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'h00;
    exp_cnt = 8'h00;
    #3;
    chk("reset_count", {24'd0, count}, 32'd0);
    chk("reset_wrap", {31'd0, wrap}, 32'd0);
    chk("reset_load_err", {31'd0, load_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full up-count cycle 00..99 then wrap to 00.
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, to_bcd((i + 1) % 100), (i == 99), 1'b0);
    end

    //               en    up    clr   load  lv     cnt    wrap  err
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h04, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h30, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h30, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h47, 8'h47, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h12, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h13, 1'b0, 1'b0});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'hFA, 8'h00, 1'b0, 1'b1});
    vt.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0});
    vt.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].en, vt[i].up, vt[i].clr, vt[i].load, vt[i].lv,
           vt[i].cnt, vt[i].wrap, vt[i].err);
    end

    // Reset at 63 clears immediately and leaves no pulse behind.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h63, 8'h63, 1'b0, 1'b0);
    pulse_reset();
    idle(8'h00);

    // A pending wrap pulse is killed by reset.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    pulse_reset();
    idle(8'h00);

    // A pending load_err pulse is killed by reset; first edge after is normal.
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 8'h00, 1'b0, 1'b1);
    pulse_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
